// File: rtl/phase_to_sine_pkg.sv
// Fixed-point widths and saturation constants for the interferometer phase-to-sine pipeline.
package phase_to_sine_pkg;

  localparam int PHASE_W = 16;
  localparam int K_W     = 18;
  localparam int OUT_W   = 12;
  localparam int PROD_W  = 34;

  localparam logic [OUT_W-1:0] SAT_POS = 12'h7FF;
  localparam logic [OUT_W-1:0] SAT_NEG = 12'h800;

  typedef struct packed {
    logic [OUT_W-1:0] dout;
    logic             sat;
  } out_t;

endpackage

// File: rtl/phase_to_sine_avg.sv
// Block averager: sums 2^AVG_LOG2 phase differences and emits their floor mean.
module phase_avg
  import phase_to_sine_pkg::*;
#(
  parameter int AVG_LOG2 = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ce,
  input  logic signed [PHASE_W-1:0] diff_i,
  input  logic                      vld_i,
  input  logic                      sync_i,
  output logic signed [PHASE_W-1:0] mean_o,
  output logic                      vld_o
);

  localparam int ACC_W = PHASE_W + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  logic signed [ACC_W-1:0]   acc_q, acc_d, acc_base, sum;
  logic        [CNT_W-1:0]   cnt_q, cnt_d, cnt_base;
  logic signed [PHASE_W-1:0] mean_q, mean_d;
  logic                      vld_q, vld_d;
  logic                      last;

  // sync is aligned with diff_i, so a sample arriving with it starts the new block
  always_comb begin
    acc_base = sync_i ? '0 : acc_q;
    cnt_base = sync_i ? '0 : cnt_q;
    sum      = acc_base + ACC_W'(diff_i);
    last     = (AVG_LOG2 == 0) || (cnt_base == CNT_LAST);
    acc_d    = acc_base;
    cnt_d    = cnt_base;
    mean_d   = mean_q;
    vld_d    = 1'b0;
    if (vld_i) begin
      if (last) begin
        acc_d  = '0;
        cnt_d  = '0;
        mean_d = PHASE_W'(sum >>> AVG_LOG2);
        vld_d  = 1'b1;
      end else begin
        acc_d = sum;
        cnt_d = cnt_base + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      mean_q <= '0;
      vld_q  <= 1'b0;
    end else if (ce) begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      mean_q <= mean_d;
      vld_q  <= vld_d;
    end
  end

  assign mean_o = mean_q;
  assign vld_o  = vld_q;

endmodule

// File: rtl/phase_to_sine.sv
// Converts the A/B antenna phase difference into a block-averaged, scaled sin(theta)
// estimate in Q1.11 for the arcsin LUT. Four ce-gated stages: diff, mean, scale, clip.
module phase_to_sine
  import phase_to_sine_pkg::*;
#(
  parameter int                      AVG_LOG2 = 4,
  parameter logic signed [K_W-1:0]   K_COEF   = 18'sh10000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ce,
  input  logic signed [PHASE_W-1:0] phase_a,
  input  logic signed [PHASE_W-1:0] phase_b,
  input  logic                      din_valid,
  input  logic                      sync,
  output logic signed [OUT_W-1:0]   dout,
  output logic                      dout_valid,
  output logic                      sat
);

  // Q3.31 product fits Q1.31 exactly when its top three bits agree
  function automatic out_t saturate(input logic signed [PROD_W-1:0] p);
    out_t r;
    if (!p[PROD_W-1] && (p[PROD_W-2:PROD_W-3] != 2'b00)) begin
      r.dout = SAT_POS;
      r.sat  = 1'b1;
    end else if (p[PROD_W-1] && (p[PROD_W-2:PROD_W-3] != 2'b11)) begin
      r.dout = SAT_NEG;
      r.sat  = 1'b1;
    end else begin
      r.dout = p[PROD_W-3 -: OUT_W];
      r.sat  = 1'b0;
    end
    return r;
  endfunction

  logic signed [PHASE_W-1:0] diff_d, diff_p1_q;
  logic                      vld_p1_q, sync_p1_q;
  logic signed [PHASE_W-1:0] mean_p2;
  logic                      vld_p2;
  logic signed [PROD_W-1:0]  prod_d, prod_p3_q;
  logic                      vld_p3_q;
  logic        [OUT_W-1:0]   dout_q;
  logic                      dout_valid_q, sat_q;
  out_t                      res_d;

  // Stage 1: modulo-2^16 subtraction wraps the difference into [-pi, pi)
  assign diff_d = phase_a - phase_b;

  // Stage 2: block mean
  phase_avg #(
    .AVG_LOG2(AVG_LOG2)
  ) u_avg (
    .clk   (clk),
    .rst   (rst),
    .ce    (ce),
    .diff_i(diff_p1_q),
    .vld_i (vld_p1_q),
    .sync_i(sync_p1_q),
    .mean_o(mean_p2),
    .vld_o (vld_p2)
  );

  // Stage 3/4: full-precision scale, then clip to Q1.11
  assign prod_d = PROD_W'(mean_p2) * PROD_W'(K_COEF);
  assign res_d  = saturate(prod_p3_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      diff_p1_q    <= '0;
      vld_p1_q     <= 1'b0;
      sync_p1_q    <= 1'b0;
      prod_p3_q    <= '0;
      vld_p3_q     <= 1'b0;
      dout_q       <= '0;
      sat_q        <= 1'b0;
      dout_valid_q <= 1'b0;
    end else if (ce) begin
      diff_p1_q    <= diff_d;
      vld_p1_q     <= din_valid;
      sync_p1_q    <= sync;
      prod_p3_q    <= prod_d;
      vld_p3_q     <= vld_p2;
      dout_valid_q <= vld_p3_q;
      if (vld_p3_q) begin
        dout_q <= res_d.dout;
        sat_q  <= res_d.sat;
      end
    end
  end

  assign dout       = dout_q;
  assign sat        = sat_q;
  assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_phase_to_sine.sv
// Bench for phase_to_sine: three parameterisations driven in parallel and compared every
// cycle against a block-sum arithmetic model, plus directed scenario checks.
module tb_phase_to_sine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b0, din_valid = 1'b0, sync = 1'b0;
  logic [15:0] pa = '0, pb = '0;

  always #5 clk = ~clk;

  logic        dv_w   [3];
  logic [11:0] dout_w [3];
  logic        sat_w  [3];

  localparam int LG [3] = '{2, 2, 0};
  localparam int KC [3] = '{65536, 98304, -49152};

  phase_to_sine #(.AVG_LOG2(2), .K_COEF(18'sh10000)) dut_a (
    .clk(clk), .rst(rst), .ce(ce), .phase_a(pa), .phase_b(pb), .din_valid(din_valid),
    .sync(sync), .dout(dout_w[0]), .dout_valid(dv_w[0]), .sat(sat_w[0]));
  phase_to_sine #(.AVG_LOG2(2), .K_COEF(18'sh18000)) dut_b (
    .clk(clk), .rst(rst), .ce(ce), .phase_a(pa), .phase_b(pb), .din_valid(din_valid),
    .sync(sync), .dout(dout_w[1]), .dout_valid(dv_w[1]), .sat(sat_w[1]));
  phase_to_sine #(.AVG_LOG2(0), .K_COEF(-18'sd49152)) dut_c (
    .clk(clk), .rst(rst), .ce(ce), .phase_a(pa), .phase_b(pb), .din_valid(din_valid),
    .sync(sync), .dout(dout_w[2]), .dout_valid(dv_w[2]), .sat(sat_w[2]));

  int checks = 0, failures = 0;
  int ecnt = 0;
  int msum [3], mcnt [3];
  logic        pv [3][8];
  logic [11:0] pd [3][8];
  logic        ps [3][8];
  logic        edv [3];
  logic [11:0] edo [3];
  logic        esat [3];
  int pulses [3];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      msum[i] = 0; mcnt[i] = 0;
      edv[i] = 1'b0; edo[i] = '0; esat[i] = 1'b0;
      for (int j = 0; j < 8; j++) begin
        pv[i][j] = 1'b0; pd[i][j] = '0; ps[i][j] = 1'b0;
      end
    end
  endtask

  // One ce-enabled clock: block-sum bookkeeping, expected output due three edges later
  task automatic model_edge();
    logic signed [15:0] d16;
    int d, mean, slot;
    longint p;
    ecnt++;
    d16 = pa - pb;
    d = int'(d16);
    for (int i = 0; i < 3; i++) begin
      if (sync) begin msum[i] = 0; mcnt[i] = 0; end
      if (din_valid) begin
        msum[i] += d;
        mcnt[i]++;
        if (mcnt[i] == (1 << LG[i])) begin
          mean = msum[i] >>> LG[i];
          p = longint'(mean) * longint'(KC[i]);
          slot = (ecnt + 3) % 8;
          pv[i][slot] = 1'b1;
          if (p >= 64'sd2147483648) begin
            pd[i][slot] = 12'h7FF; ps[i][slot] = 1'b1;
          end else if (p < -64'sd2147483648) begin
            pd[i][slot] = 12'h800; ps[i][slot] = 1'b1;
          end else begin
            pd[i][slot] = 12'(p >>> 20); ps[i][slot] = 1'b0;
          end
          msum[i] = 0; mcnt[i] = 0;
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      slot = ecnt % 8;
      edv[i] = pv[i][slot];
      if (pv[i][slot]) begin edo[i] = pd[i][slot]; esat[i] = ps[i][slot]; end
      pv[i][slot] = 1'b0;
    end
  endtask

  task automatic step(input logic c, input logic v, input logic s,
                      input logic [15:0] a, input logic [15:0] b);
    ce = c; din_valid = v; sync = s; pa = a; pb = b;
    @(posedge clk);
    #1;
    if (c) model_edge();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("dv%0d@%0t", i, $time), 32'(dv_w[i]), 32'(edv[i]));
      chk($sformatf("dout%0d@%0t", i, $time), 32'(dout_w[i]), 32'(edo[i]));
      chk($sformatf("sat%0d@%0t", i, $time), 32'(sat_w[i]), 32'(esat[i]));
      if (c && dv_w[i]) pulses[i]++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; ce = 1'b0; din_valid = 1'b0; sync = 1'b0;
    @(posedge clk);
    #1;
    model_clear();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_dv%0d", i), 32'(dv_w[i]), 32'd0);
      chk($sformatf("rst_dout%0d", i), 32'(dout_w[i]), 32'd0);
      chk($sformatf("rst_sat%0d", i), 32'(sat_w[i]), 32'd0);
    end
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic blk(input int n, input logic [15:0] a, input logic [15:0] b);
    repeat (n) step(1'b1, 1'b1, 1'b0, a, b);
  endtask

  task automatic clr_pulses();
    for (int i = 0; i < 3; i++) pulses[i] = 0;
  endtask

  initial begin
    model_clear();
    clr_pulses();
    do_reset();

    clr_pulses();
    blk(4, 16'h4000, 16'h0000); idle(6);
    chk("r031_pulses", 32'(pulses[0]), 32'd1);
    chk("r031_dout", 32'(dout_w[0]), 32'h400);
    chk("r031_sat", 32'(sat_w[0]), 32'd0);

    blk(4, 16'h7000, 16'h9000); idle(6);
    chk("r032_dout", 32'(dout_w[0]), 32'hE00);
    chk("r032_sat", 32'(sat_w[0]), 32'd0);

    blk(4, 16'h6000, 16'h0000); idle(6);
    chk("r033_pos_dout", 32'(dout_w[1]), 32'h7FF);
    chk("r033_pos_sat", 32'(sat_w[1]), 32'd1);
    blk(4, 16'h8000, 16'h0000); idle(6);
    chk("r033_neg_dout", 32'(dout_w[1]), 32'h800);
    chk("r033_neg_sat", 32'(sat_w[1]), 32'd1);

    clr_pulses();
    blk(2, 16'h1000, 16'h0000);
    step(1'b1, 1'b1, 1'b1, 16'h2000, 16'h0000);
    blk(3, 16'h2000, 16'h0000); idle(6);
    chk("r034a_pulses", 32'(pulses[0]), 32'd1);
    chk("r034a_dout", 32'(dout_w[0]), 32'h200);

    clr_pulses();
    blk(4, 16'h1800, 16'h0000);
    step(1'b1, 1'b0, 1'b1, 16'h0, 16'h0);
    idle(6);
    chk("r034b_pulses", 32'(pulses[0]), 32'd1);
    chk("r034b_dout", 32'(dout_w[0]), 32'h180);

    clr_pulses();
    blk(3, 16'h3000, 16'h0000);
    do_reset();
    idle(6);
    chk("r035_nopulse", 32'(pulses[0]), 32'd0);
    blk(4, 16'h0800, 16'h0000); idle(6);
    chk("r035_pulses", 32'(pulses[0]), 32'd1);
    chk("r035_dout", 32'(dout_w[0]), 32'h080);

    clr_pulses();
    for (int k = 0; k < 32; k++)
      step(1'b1, 1'b1, 1'b0, 16'($urandom), 16'($urandom));
    for (int k = 0; k < 64; k++)
      step(k[0] == 1'b0, 1'b1, 1'b0, 16'($urandom), 16'($urandom));
    idle(6);
    chk("r036_pulses", 32'(pulses[0]), 32'd16);

    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 39) == 0, 16'($urandom), 16'($urandom));
    end
    idle(8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
